// File: rtl/riscv_v_bw_reduct_unit_if.sv
`default_nettype none
// ============================================================================
// riscv_v_bw_reduct_unit_if : beat-input / result-output bundle
// Rev 1.0
// ============================================================================
interface riscv_v_bw_reduct_unit_if #(
  parameter int DATA_BYTES = 16,
  parameter int MAX_BEATS  = 8
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_op;
  logic                    in_reduct;
  logic [1:0]              in_osize;
  logic                    in_last;
  logic [DATA_BYTES*8-1:0] srca_data;
  logic [DATA_BYTES-1:0]   srca_valid;
  logic [DATA_BYTES*8-1:0] srcb_data;
  logic [DATA_BYTES-1:0]   srcb_valid;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_BYTES*8-1:0] out_data;
  logic [DATA_BYTES-1:0]   out_byte_valid;
  logic [CW-1:0]           out_beats;

  modport master (
    output in_valid, in_op, in_reduct, in_osize, in_last,
           srca_data, srca_valid, srcb_data, srcb_valid, out_ready,
    input  in_ready, out_valid, out_data, out_byte_valid, out_beats
  );

  modport slave (
    input  in_valid, in_op, in_reduct, in_osize, in_last,
           srca_data, srca_valid, srcb_data, srcb_valid, out_ready,
    output in_ready, out_valid, out_data, out_byte_valid, out_beats
  );
endinterface
`default_nettype wire

// File: rtl/riscv_v_bw_reduct_unit.sv
`default_nettype none
// ============================================================================
// riscv_v_bw_reduct_unit : vector bitwise AND/OR/XOR, element-wise or reduction
// Rev 1.0
// ============================================================================
module riscv_v_bw_reduct_unit #(
  parameter int DATA_BYTES = 16,
  parameter int MAX_BEATS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  riscv_v_bw_reduct_unit_if.slave  bus
);
  localparam int DW = DATA_BYTES * 8;
  localparam int NL = DATA_BYTES / 8;
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [1:0]            osize_q, osize_d;
  logic [63:0]           acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic [DW-1:0]         od_q, od_d;
  logic [DATA_BYTES-1:0] obv_q, obv_d;
  logic [CW-1:0]         obeats_q, obeats_d;

  logic [1:0]            w_op, w_osize;
  logic                  w_reduct, w_accept;
  logic [DW-1:0]         w_srcb_m, w_ew_data;
  logic [63:0]           w_f64, w_f32, w_f16, w_f8;
  logic [63:0]           w_fold_e, w_srca_e, w_acc_new;
  logic [DATA_BYTES-1:0] w_e_bv;
  logic [CW-1:0]         w_cnt_next;

  function automatic logic [63:0] bw_op(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] op);
    logic [63:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign bus.in_ready = (!ov_q | bus.out_ready) & !flush;
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Controls come from the live inputs only on the first beat; later beats reuse them.
  always_comb begin
    w_op     = (state_q == S_IDLE) ? bus.in_op    : op_q;
    w_osize  = (state_q == S_IDLE) ? bus.in_osize : osize_q;
    w_reduct = (state_q == S_IDLE) ? bus.in_reduct : 1'b1;

    for (int b = 0; b < DATA_BYTES; b++)
      w_srcb_m[b*8 +: 8] = bus.srcb_valid[b] ? bus.srcb_data[b*8 +: 8]
                                             : ((w_op == 2'b00) ? 8'hFF : 8'h00);

    // Fold to one 64-bit lane, then halve; every narrower result stays zero-extended.
    w_f64 = w_srcb_m[63:0];
    for (int l = 1; l < NL; l++)
      w_f64 = bw_op(w_f64, w_srcb_m[l*64 +: 64], w_op);
    w_f32 = bw_op({32'h0, w_f64[63:32]}, {32'h0, w_f64[31:0]}, w_op);
    w_f16 = bw_op({48'h0, w_f32[31:16]}, {48'h0, w_f32[15:0]}, w_op);
    w_f8  = bw_op({56'h0, w_f16[15:8]},  {56'h0, w_f16[7:0]},  w_op);

    w_e_bv = '0;
    case (w_osize)
      2'd0:    begin w_fold_e = w_f8;  w_srca_e = {56'h0, bus.srca_data[7:0]};  w_e_bv[0]   = 1'b1; end
      2'd1:    begin w_fold_e = w_f16; w_srca_e = {48'h0, bus.srca_data[15:0]}; w_e_bv[1:0] = '1;   end
      2'd2:    begin w_fold_e = w_f32; w_srca_e = {32'h0, bus.srca_data[31:0]}; w_e_bv[3:0] = '1;   end
      default: begin w_fold_e = w_f64; w_srca_e = bus.srca_data[63:0];          w_e_bv[7:0] = '1;   end
    endcase

    w_acc_new = bw_op((state_q == S_IDLE) ? w_srca_e : acc_q, w_fold_e, w_op);

    for (int l = 0; l < NL; l++)
      w_ew_data[l*64 +: 64] = bw_op(bus.srca_data[l*64 +: 64], bus.srcb_data[l*64 +: 64], w_op);

    if (state_q == S_IDLE)               w_cnt_next = CW'(1);
    else if (cnt_q == CW'(MAX_BEATS))    w_cnt_next = cnt_q;
    else                                 w_cnt_next = cnt_q + CW'(1);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    osize_d  = osize_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q & !bus.out_ready;
    od_d     = od_q;
    obv_d    = obv_q;
    obeats_d = obeats_q;

    if (flush) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else if (w_accept) begin
      if (state_q == S_IDLE) begin
        op_d    = bus.in_op;
        osize_d = bus.in_osize;
      end
      if (!w_reduct) begin
        od_d     = w_ew_data;
        obv_d    = bus.srca_valid;
        obeats_d = CW'(1);
        ov_d     = 1'b1;
      end else if (bus.in_last) begin
        od_d        = '0;
        od_d[63:0]  = w_acc_new;
        obv_d       = w_e_bv;
        obeats_d    = w_cnt_next;
        ov_d        = 1'b1;
        state_d     = S_IDLE;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        state_d = S_ACCUM;
        acc_d   = w_acc_new;
        cnt_d   = w_cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      osize_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      obv_q    <= '0;
      obeats_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      osize_q  <= osize_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      obv_q    <= obv_d;
      obeats_q <= obeats_d;
    end
  end

  assign bus.out_valid      = ov_q;
  assign bus.out_data       = od_q;
  assign bus.out_byte_valid = obv_q;
  assign bus.out_beats      = obeats_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_v_bw_reduct_unit.sv
`default_nettype none
// ============================================================================
// tb_riscv_v_bw_reduct_unit : directed vectors plus multi-cycle sequences
// Rev 1.0
// ============================================================================
module tb_riscv_v_bw_reduct_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  riscv_v_bw_reduct_unit_if #(.DATA_BYTES(16), .MAX_BEATS(8)) bus ();

  riscv_v_bw_reduct_unit #(.DATA_BYTES(16), .MAX_BEATS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic         reduct;
    logic [1:0]   osize;
    logic [127:0] a;
    logic [15:0]  av;
    logic [127:0] b;
    logic [15:0]  bv;
    logic [127:0] exp_d;
    logic [15:0]  exp_bv;
    logic [3:0]   exp_beats;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic red, input logic [1:0] os,
                       input logic last, input logic [127:0] a, input logic [15:0] av,
                       input logic [127:0] b, input logic [15:0] bv);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_reduct  = red;
    bus.in_osize   = os;
    bus.in_last    = last;
    bus.srca_data  = a;
    bus.srca_valid = av;
    bus.srcb_data  = b;
    bus.srcb_valid = bv;
  endtask

  task automatic beat(input logic [1:0] op, input logic red, input logic [1:0] os,
                      input logic last, input logic [127:0] a, input logic [15:0] av,
                      input logic [127:0] b, input logic [15:0] bv);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(op, red, os, last, a, av, b, bv);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [127:0] d, input logic [15:0] bv,
                         input logic [3:0] beats);
    chk({name, ".valid"}, {127'h0, bus.out_valid}, 128'h1);
    chk({name, ".data"},  bus.out_data, d);
    chk({name, ".bv"},    {112'h0, bus.out_byte_valid}, {112'h0, bv});
    chk({name, ".beats"}, {124'h0, bus.out_beats}, {124'h0, beats});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op     red   os    srca                                      av        srcb                                      bv        exp data                                  exp bv    beats
    vt[0] = '{2'b10, 1'b0, 2'd0, {16{8'hFF}},                             16'h00FF, {16{8'h0F}},                             16'hFFFF, {16{8'hF0}},                             16'h00FF, 4'd1};
    vt[1] = '{2'b00, 1'b0, 2'd0, 128'h0123456789ABCDEF_FEDCBA9876543210,  16'hFFFF, {16{8'hF0}},                             16'hFFFF, 128'h0020406080A0C0E0_F0D0B09070503010,  16'hFFFF, 4'd1};
    vt[2] = '{2'b01, 1'b0, 2'd0, {16{8'h0F}},                             16'hA5A5, {16{8'h30}},                             16'hFFFF, {16{8'h3F}},                             16'hA5A5, 4'd1};
    vt[3] = '{2'b11, 1'b0, 2'd0, {16{8'hFF}},                             16'hFFFF, {16{8'h0F}},                             16'hFFFF, 128'h0,                                  16'hFFFF, 4'd1};
    vt[4] = '{2'b00, 1'b1, 2'd2, 128'h00000000_FFFFFFFF,                  16'hFFFF, 128'h00000000_00000000_FF0FFFFF_FFFF00FF, 16'h00FF, 128'hFF0F00FF,                           16'h000F, 4'd1};
    vt[5] = '{2'b10, 1'b1, 2'd1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF1234, 16'hFFFF, 128'h0001_0002_0004_0008_0010_0020_0040_0080, 16'hFFFF, 128'h12CB,                      16'h0003, 4'd1};
    vt[6] = '{2'b10, 1'b1, 2'd3, {64'hAAAAAAAAAAAAAAAA, 64'hFFFF0000FFFF0000}, 16'hFFFF, {64'h0F0F0F0F0F0F0F0F, 64'h00000000FFFFFFFF}, 16'h00FF, 128'hFFFF00000000FFFF, 16'h00FF, 4'd1};
    vt[7] = '{2'b01, 1'b1, 2'd0, 128'h0,                                  16'hFFFF, {64'h0101010101010101, 64'h0101800101010101}, 16'h0001, 128'h01,                    16'h0001, 4'd1};
    vt[8] = '{2'b11, 1'b1, 2'd2, {16{8'hFF}},                             16'hFFFF, {16{8'hFF}},                             16'hFFFF, 128'h0,                                  16'h000F, 4'd1};

    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b00, 1'b0, 2'd0, 1'b0, '0, '0, '0, '0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", {127'h0, bus.out_valid}, 128'h0);
    chk("reset.data",  bus.out_data, 128'h0);
    chk("reset.bv",    {112'h0, bus.out_byte_valid}, 128'h0);
    chk("reset.beats", {124'h0, bus.out_beats}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat vectors: element-wise and one-beat reductions.
    for (int i = 0; i < 9; i++) begin
      beat(vt[i].op, vt[i].reduct, vt[i].osize, 1'b1, vt[i].a, vt[i].av, vt[i].b, vt[i].bv);
      chk_out($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_bv, vt[i].exp_beats);
    end

    // Two-beat OR reduction; second beat carries junk controls that must be ignored.
    beat(2'b01, 1'b1, 2'd0, 1'b0, 128'h01, 16'hFFFF, 128'h02000000, 16'hFFFF);
    chk("or2.mid_valid", {127'h0, bus.out_valid}, 128'h0);
    beat(2'b00, 1'b0, 2'd3, 1'b1, {16{8'hFF}}, 16'hFFFF, {8'h80, 120'h0}, 16'hFFFF);
    chk_out("or2", 128'h83, 16'h0001, 4'd2);

    // Ten-beat XOR reduction: counter saturates at 8 without ending the reduction.
    for (int k = 0; k < 10; k++) begin
      logic [127:0] b;
      b = '0;
      b[7:0] = 8'(1 << (k % 8));
      beat(2'b10, 1'b1, 2'd0, (k == 9), 128'h0, 16'hFFFF, b, 16'hFFFF);
      if (k == 8) chk("sat.mid_valid", {127'h0, bus.out_valid}, 128'h0);
    end
    chk_out("sat", 128'hFC, 16'h0001, 4'd8);

    // Backpressure: result held for three cycles, then drained with a new beat.
    idle();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vt[0].op, 1'b0, 2'd0, 1'b1, vt[0].a, vt[0].av, vt[0].b, vt[0].bv);
    @(posedge clk);
    #1;
    chk_out("bp.load", vt[0].exp_d, vt[0].exp_bv, 4'd1);
    drive(vt[1].op, 1'b0, 2'd0, 1'b1, vt[1].a, vt[1].av, vt[1].b, vt[1].bv);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp.in_ready%0d", i), {127'h0, bus.in_ready}, 128'h0);
      @(posedge clk);
      #1;
      chk_out($sformatf("bp.hold%0d", i), vt[0].exp_d, vt[0].exp_bv, 4'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp.in_ready_rel", {127'h0, bus.in_ready}, 128'h1);
    @(posedge clk);
    #1;
    chk_out("bp.reload", vt[1].exp_d, vt[1].exp_bv, 4'd1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp.drain", {127'h0, bus.out_valid}, 128'h0);

    // Flush after two reduction beats, then a fresh one-beat OR.
    beat(2'b01, 1'b1, 2'd0, 1'b0, 128'h0, 16'hFFFF, 128'hF0, 16'hFFFF);
    beat(2'b01, 1'b1, 2'd0, 1'b0, 128'h0, 16'hFFFF, 128'hF0, 16'hFFFF);
    @(negedge clk);
    flush = 1'b1;
    drive(2'b01, 1'b1, 2'd0, 1'b1, 128'h0, 16'hFFFF, 128'h0C, 16'hFFFF);
    #1;
    chk("flush.in_ready", {127'h0, bus.in_ready}, 128'h0);
    @(posedge clk);
    #1;
    chk("flush.valid", {127'h0, bus.out_valid}, 128'h0);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    beat(2'b01, 1'b1, 2'd0, 1'b1, 128'h0, 16'hFFFF, 128'h03, 16'hFFFF);
    chk_out("flush.fresh", 128'h03, 16'h0001, 4'd1);

    // Flush also drops a pending result that is being held.
    @(negedge clk);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush.pending", {127'h0, bus.out_valid}, 128'h0);
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b1;

    // Reset mid-reduction, then an uncontaminated one-beat XOR.
    beat(2'b10, 1'b1, 2'd0, 1'b0, 128'h0, 16'hFFFF, 128'h11, 16'hFFFF);
    beat(2'b10, 1'b1, 2'd0, 1'b0, 128'h0, 16'hFFFF, 128'h22, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.valid", {127'h0, bus.out_valid}, 128'h0);
    chk("rst.data",  bus.out_data, 128'h0);
    chk("rst.bv",    {112'h0, bus.out_byte_valid}, 128'h0);
    chk("rst.beats", {124'h0, bus.out_beats}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(2'b10, 1'b1, 2'd0, 1'b1, 128'h0, 16'hFFFF, 128'h5A, 16'hFFFF);
    chk_out("rst.fresh", 128'h5A, 16'h0001, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/riscv_v_bw_reduct_unit.md
RISCV_V_BW_REDUCT_UNIT -- requirements
Module: riscv_v_bw_reduct_unit

Interface
REQ-001 Parameter DATA_BYTES, default 16, meaning bytes per vector beat; power of two, >=8.
REQ-002 Parameter MAX_BEATS, default 8, meaning beat-counter saturation value; >=1.
REQ-003 clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 flush  input  1  meaning synchronous abort of any reduction and of the pending output.
REQ-006 in_valid / in_ready  input / output  1 / 1  meaning input beat handshake.
REQ-007 in_op  input  2  meaning 00 AND, 01 OR, 10 XOR, 11 reserved.
REQ-008 in_reduct  input  1  meaning 1 for a reduction, 0 for element-wise.
REQ-009 in_osize  input  2  meaning element width of 8/16/32/64 bits for codes 0/1/2/3.
REQ-010 in_last  input  1  meaning final beat of a reduction.
REQ-011 srca_data / srca_valid  input  DATA_BYTES*8 / DATA_BYTES  meaning source A bytes and per-byte valid.
REQ-012 srcb_data / srcb_valid  input  DATA_BYTES*8 / DATA_BYTES  meaning source B bytes and per-byte valid.
REQ-013 out_valid / out_ready  output / input  1 / 1  meaning result handshake.
REQ-014 out_data / out_byte_valid  output  DATA_BYTES*8 / DATA_BYTES  meaning result bytes and mask.
REQ-015 out_beats  output  $clog2(MAX_BEATS+1)  meaning number of beats folded into the presented result.

Function
REQ-016 The FSM SHALL have the states IDLE and ACCUM.
REQ-017 in_ready SHALL equal (!out_valid | out_ready) & !flush; a beat is accepted when in_valid & in_ready.
REQ-018 An element-wise beat accepted in IDLE SHALL load out_data = srca op srcb per byte, out_byte_valid = srca_valid and out_beats = 1, and SHALL assert out_valid on the next cycle.
REQ-019 op, reduct and osize SHALL be sampled on the first beat accepted in IDLE; in ACCUM these inputs are ignored and each beat is treated as a reduction continuation.
REQ-020 Invalid srcb bytes SHALL be replaced by the op identity before folding: 0xFF for AND, 0x00 for OR and XOR.
REQ-021 Each reduction beat SHALL fold all DATA_BYTES/esize elements of the masked srcb into a single element with a combinational tree, in one cycle.
REQ-022 The first reduction beat SHALL seed the accumulator with srca element 0 op fold(srcb).
REQ-023 Later reduction beats SHALL set the accumulator to accumulator op fold(srcb).
REQ-024 A reduction beat with in_last=0 SHALL move the FSM to (or keep it in) ACCUM.
REQ-025 A reduction beat with in_last=1 SHALL load out_data with the accumulated element in the low esize bytes and zeros elsewhere, SHALL set out_byte_valid to the low esize bits, SHALL assert out_valid on the next cycle and SHALL return the FSM to IDLE.
REQ-026 A single-beat reduction (in_last=1 on the first beat) SHALL be legal and SHALL have 1-cycle latency.
REQ-027 The beat counter SHALL increment per accepted beat and saturate at MAX_BEATS; saturation SHALL NOT terminate the reduction.
REQ-028 in_op=11 SHALL produce an all-zero result with the normal masks and timing.
REQ-029 out_data, out_byte_valid and out_beats SHALL hold stable while out_valid & !out_ready.
REQ-030 out_valid SHALL clear on out_ready unless a completing beat is accepted in the same cycle, in which case the output register reloads and out_valid stays 1.
REQ-031 flush SHALL win over an input beat, clear out_valid, clear the accumulator and counter, and force IDLE on the next edge.

Reset
REQ-032 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and out_valid, out_data, out_byte_valid, out_beats, the accumulator and the counter SHALL clear to 0.
REQ-033 Reset mid-reduction SHALL discard all partial state; the first beat after reset starts a new operation.

Verification
REQ-034 Element-wise XOR: srca bytes 0xFF, srcb bytes 0x0F, srca_valid=0x00FF -> next cycle out_valid=1, out_data bytes 0xF0, out_byte_valid=0x00FF, out_beats=1.
REQ-035 OR reduction, osize 0, two beats: srca byte0=0x01; beat 1 srcb byte3=0x02, other bytes 0; beat 2 (last) byte15=0x80 -> out byte0=0x83, out_byte_valid=0x0001, out_beats=2.
REQ-036 AND reduction, osize 2, srcb_valid=0x00FF, elements 0xFFFF00FF and 0xFF0FFFFF, upper bytes 0x00, srca element 0=0xFFFFFFFF -> result 0xFF0F00FF, out_byte_valid=0x000F.
REQ-037 Backpressure: out_ready=0 for 3 cycles with a result pending -> in_ready=0 and out_* stable; then out_ready=1 plus a new beat in the same cycle -> out_valid stays 1 with the new result.
REQ-038 flush after 2 reduction beats, then a fresh 1-beat OR reduction -> the result contains only the fresh data and out_beats=1.
REQ-039 rst_n=0 for one edge while in ACCUM -> all outputs 0, FSM in IDLE, and the next reduction is not contaminated by the earlier beats.
